// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor's program memory and run control.
//   state_t      : controller FSM states (3-bit encoding)
//   HALT_OPCODE  : instruction word that ends a run
//   DEF_DATA_W   : default instruction/data word width
//   DEF_ADDR_W   : default program memory address width
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4,
        ST_TOUT  = 3'd5
    } state_t;

    localparam int          DEF_DATA_W  = 16;
    localparam int          DEF_ADDR_W  = 10;
    localparam logic [15:0] HALT_OPCODE = 16'h3C00;

endpackage

// File: rtl/ram_rw_param.sv
// Single-port program RAM: synchronous write, registered read.
//   clk, rst_n : clock, async active-low reset (clears dout only)
//   we         : write enable; wins over re on the shared port
//   re         : read enable; dout <= mem[addr] on the next edge
//   addr       : shared read/write address
//   wdata      : write data
//   dout       : registered read data, holds when not reading
module ram_rw_param
    import proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto a RAM macro; contents
    // survive rst_n and are only defined once written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (re && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/prog_mem_run_ctrl.sv
// Program memory plus load/run/halt controller for the simple processor.
//   ld_start/ld_valid/ld_data/ld_last/ld_ready : streamed program image in
//   run_go      : start execution of the loaded image
//   pc/ram_read_en -> instr/instr_vld : fetch port, one cycle latency
//   proc_start  : level run request to the processor
//   halted/timeout : run ended on HALT_OP / on the cycle limit (sticky)
//   cycle_cnt   : RUN cycles of the current or last run
//   ld_count    : words written by the last load
module prog_mem_run_ctrl
    import proc_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(HALT_OPCODE),
    parameter int                TIMEOUT = 1024,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              run_go,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ram_read_en,
    output logic [DATA_W-1:0] instr,
    output logic              instr_vld,
    output logic              proc_start,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [ADDR_W:0]   ld_count
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ld_addr;
    logic              load_beat;
    logic              ld_addr_end;
    logic              fetch_en;
    logic              halt_seen;
    logic              cnt_end;
    logic              enter_load;
    logic              enter_run;

    assign load_beat   = (state == ST_LOAD) && ld_valid;
    assign ld_addr_end = (ld_addr == '1);
    // Fetches are dropped while loading so the write port is never contended.
    assign fetch_en    = ram_read_en && (state != ST_LOAD);
    assign halt_seen   = instr_vld && (instr == HALT_OP);
    assign cnt_end     = (cycle_cnt == CNT_W'(TIMEOUT - 1));
    assign enter_load  = (state != ST_LOAD) && (state_nxt == ST_LOAD);
    assign enter_run   = (state != ST_RUN)  && (state_nxt == ST_RUN);

    // Status outputs decode straight from state so rst_n clears them at once.
    assign ld_ready   = (state == ST_LOAD);
    assign proc_start = (state == ST_RUN);
    assign halted     = (state == ST_HALT);
    assign timeout    = (state == ST_TOUT);

    ram_rw_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_beat),
        .re    (fetch_en),
        .addr  ((state == ST_LOAD) ? ld_addr : pc),
        .wdata (ld_data),
        .dout  (instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ld_start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_beat && (ld_last || ld_addr_end)) state_nxt = ST_READY;
            end
            ST_READY, ST_HALT, ST_TOUT: begin
                if (ld_start)    state_nxt = ST_LOAD;
                else if (run_go) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // HALT outranks the cycle limit when both land together.
                if (halt_seen)    state_nxt = ST_HALT;
                else if (cnt_end) state_nxt = ST_TOUT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_addr   <= '0;
            ld_count  <= '0;
            cycle_cnt <= '0;
            instr_vld <= 1'b0;
        end else begin
            instr_vld <= fetch_en;

            if (enter_load) begin
                ld_addr  <= '0;
                ld_count <= '0;
            end else if (load_beat) begin
                ld_count <= ld_count + 1'b1;
                // The final address ends the load, so it is never stepped past.
                if (!ld_addr_end) ld_addr <= ld_addr + 1'b1;
            end

            if (enter_load || enter_run) begin
                cycle_cnt <= '0;
            end else if (state == ST_RUN) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

endmodule
